// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: address geometry,
// the FSM state encoding and an alignment helper.
package pc_seq_pkg;

  localparam int PC_WIDTH        = 64;
  localparam int INSN_ALIGN_BITS = 2;
  localparam int CNT_WIDTH       = 4;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_TRAP  = 2'd2
  } state_t;

  function automatic logic is_aligned(input logic [PC_WIDTH-1:0] addr);
    return addr[INSN_ALIGN_BITS-1:0] == '0;
  endfunction

endpackage

// File: rtl/flush_counter.sv
// Loadable 4-bit down-counter that times the front-end flush window.
// It saturates at zero, so an idle count_en has no effect.
module flush_counter
  import pc_seq_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_value,
  input  logic                 count_en,
  output logic                 zero
);

  logic [CNT_WIDTH-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (count_en && count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner: sequential advance, branch redirect with a counted
// flush, and a sticky trap on misaligned branch targets.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [63:0] RESET_PC     = 64'h0,
  parameter int          PC_STEP      = 4,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        fetch_ready,
  input  logic        br_taken,
  input  logic [63:0] br_target,
  output logic [63:0] pc,
  output logic        pc_valid,
  output logic        flush,
  output logic        misalign_trap,
  output logic [63:0] trap_pc
);

  state_t              state_reg, state_next;
  logic [PC_WIDTH-1:0] pc_reg, pc_next;
  logic                live_reg;
  logic                trap_reg;
  logic [PC_WIDTH-1:0] trap_pc_reg;
  logic                cnt_zero;
  logic                branch, br_ok, br_bad, fire;

  // Branches only count in RUN; during FLUSH they come from squashed wrong-path code.
  assign branch = br_taken && (state_reg == ST_RUN);
  assign br_ok  = branch && is_aligned(br_target);
  assign br_bad = branch && !is_aligned(br_target);
  assign fire   = pc_valid && fetch_ready && !stall && !branch;

  // Loaded with one less than the window so FLUSH lasts exactly FLUSH_CYCLES.
  flush_counter u_flush_counter (
    .clk        (clk),
    .reset      (reset),
    .load       (br_ok),
    .load_value (CNT_WIDTH'(FLUSH_CYCLES - 1)),
    .count_en   (state_reg == ST_FLUSH),
    .zero       (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RUN: begin
        if (br_ok) begin
          state_next = ST_FLUSH;
        end else if (br_bad) begin
          state_next = ST_TRAP;
        end
      end
      ST_FLUSH: begin
        if (cnt_zero) begin
          state_next = ST_RUN;
        end
      end
      ST_TRAP:  state_next = ST_TRAP;
      default:  state_next = ST_RUN;
    endcase
  end

  always_comb begin
    pc_valid = live_reg && (state_reg != ST_TRAP);
    flush    = (state_reg == ST_FLUSH) || (state_reg == ST_TRAP);
  end

  always_comb begin
    pc_next = pc_reg;
    if (br_ok) begin
      pc_next = br_target;
    end else if (fire) begin
      pc_next = pc_reg + PC_WIDTH'(PC_STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg      <= RESET_PC;
      live_reg    <= 1'b0;
      trap_reg    <= 1'b0;
      trap_pc_reg <= '0;
    end else begin
      pc_reg   <= pc_next;
      live_reg <= 1'b1;
      if (br_bad) begin
        trap_reg    <= 1'b1;
        trap_pc_reg <= br_target;
      end
    end
  end

  assign pc            = pc_reg;
  assign misalign_trap = trap_reg;
  assign trap_pc       = trap_pc_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_pc_sequencer;

  localparam logic [63:0] RESET_PC     = 64'h0;
  localparam int          PC_STEP      = 4;
  localparam int          FLUSH_CYCLES = 2;

  logic        clk = 1'b0;
  logic        reset, stall, fetch_ready, br_taken;
  logic [63:0] br_target;
  logic [63:0] pc, trap_pc;
  logic        pc_valid, flush, misalign_trap;

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 1'b0;

  pc_sequencer #(
    .RESET_PC     (RESET_PC),
    .PC_STEP      (PC_STEP),
    .FLUSH_CYCLES (FLUSH_CYCLES)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .fetch_ready   (fetch_ready),
    .br_taken      (br_taken),
    .br_target     (br_target),
    .pc            (pc),
    .pc_valid      (pc_valid),
    .flush         (flush),
    .misalign_trap (misalign_trap),
    .trap_pc       (trap_pc)
  );

  always #5 clk = ~clk;

  // Behavioural model: remaining flush cycles, a trapped flag and the PC.
  logic [63:0] m_pc, m_trap_pc;
  bit          m_live, m_trapped;
  int          m_flush_left;

  always @(posedge clk) begin
    bit valid, take;
    if (reset) begin
      m_pc = RESET_PC; m_live = 0; m_flush_left = 0; m_trapped = 0; m_trap_pc = 64'h0;
    end else if (!m_trapped) begin
      valid = m_live;
      take  = br_taken && (m_flush_left == 0);
      if (m_flush_left > 0) m_flush_left = m_flush_left - 1;
      if (take) begin
        if (br_target[1:0] != 2'b00) begin
          m_trapped = 1; m_trap_pc = br_target;
        end else begin
          m_pc = br_target; m_flush_left = FLUSH_CYCLES;
        end
      end else if (valid && fetch_ready && !stall) begin
        m_pc = m_pc + 64'(PC_STEP);
      end
      m_live = 1;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      n_checks++;
      if (pc !== m_pc || pc_valid !== (m_live && !m_trapped) ||
          flush !== (m_flush_left > 0 || m_trapped) ||
          misalign_trap !== m_trapped || trap_pc !== m_trap_pc) begin
        n_fail++;
        $display("FAIL model t=%0t: pc=%h/%h valid=%b/%b flush=%b/%b trap=%b/%b trap_pc=%h/%h (got/exp)",
                 $time, pc, m_pc, pc_valid, m_live && !m_trapped, flush,
                 (m_flush_left > 0 || m_trapped), misalign_trap, m_trapped, trap_pc, m_trap_pc);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("check %s = %h ok", name, act);
    end
  endtask

  task automatic drive(input bit r, input bit st, input bit fr, input bit bt, input logic [63:0] tgt);
    reset = r; stall = st; fetch_ready = fr; br_taken = bt; br_target = tgt;
  endtask

  // Outputs are read at the falling edge following the active edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    drive(1, 0, 0, 0, 64'h0);
    @(negedge clk);
    step();
    checking = 1'b1;
    chk("rst_pc", pc, 64'h0);
    chk("rst_valid", {63'h0, pc_valid}, 64'h0);
    chk("rst_flush", {63'h0, flush}, 64'h0);

    // Sequential advance
    drive(0, 0, 1, 0, 64'h0);
    step(); chk("seq_valid_rise", {63'h0, pc_valid}, 64'h1); chk("seq_pc0", pc, 64'h0);
    step(); chk("seq_pc4", pc, 64'h4);
    step(); chk("seq_pc8", pc, 64'h8);
    step(); chk("seq_pcC", pc, 64'hC);

    // Redirect to 0x40, then 0x100 with ignored wrong-path branches
    drive(0, 0, 0, 1, 64'h40); step(); chk("redir40", pc, 64'h40);
    drive(0, 0, 0, 0, 64'h0);  step(); step();
    chk("flush_done40", {63'h0, flush}, 64'h0);
    drive(0, 0, 0, 1, 64'h100); step();
    chk("redir100", pc, 64'h100); chk("flush_c1", {63'h0, flush}, 64'h1);
    drive(0, 0, 0, 1, 64'h300); step();
    chk("flush_c2", {63'h0, flush}, 64'h1); chk("ign_br1", pc, 64'h100);
    step();
    chk("flush_end", {63'h0, flush}, 64'h0); chk("ign_br2", pc, 64'h100);

    // Branch beats stall and fetch_ready=0; stall alone holds
    drive(0, 1, 0, 1, 64'h200); step(); chk("prio_br", pc, 64'h200);
    drive(0, 1, 1, 0, 64'h0); step(); step(); step();
    chk("stall_hold", pc, 64'h200);

    // Wrap
    drive(0, 0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC); step(); chk("wrap_tgt", pc, 64'hFFFF_FFFF_FFFF_FFFC);
    drive(0, 0, 1, 0, 64'h0); step();
    chk("wrap_zero", pc, 64'h0); chk("wrap_notrap", {63'h0, misalign_trap}, 64'h0);
    drive(0, 0, 0, 0, 64'h0); step();

    // Misaligned target traps and freezes
    drive(0, 0, 0, 1, 64'h102); step();
    chk("trap_flag", {63'h0, misalign_trap}, 64'h1); chk("trap_pc", trap_pc, 64'h102);
    chk("trap_pc_hold", pc, 64'h0); chk("trap_valid", {63'h0, pc_valid}, 64'h0);
    chk("trap_flush", {63'h0, flush}, 64'h1);
    drive(0, 0, 1, 1, 64'h500); step(); step();
    chk("trap_frozen", pc, 64'h0); chk("trap_pc_sticky", trap_pc, 64'h102);
    drive(1, 0, 1, 1, 64'h500); step();
    chk("trap_rst_flag", {63'h0, misalign_trap}, 64'h0); chk("trap_rst_tpc", trap_pc, 64'h0);
    chk("trap_rst_flush", {63'h0, flush}, 64'h0); chk("trap_rst_valid", {63'h0, pc_valid}, 64'h0);

    // Reset during the first flush cycle
    drive(0, 0, 1, 0, 64'h0); step();
    drive(0, 0, 1, 1, 64'h80); step(); chk("fl_rst_pre", {63'h0, flush}, 64'h1);
    drive(1, 0, 1, 1, 64'h80); step();
    chk("fl_rst_flush", {63'h0, flush}, 64'h0); chk("fl_rst_pc", pc, RESET_PC);
    drive(0, 0, 1, 0, 64'h0); step(); step();
    chk("fl_rst_run", pc, 64'h4);

    // Randomized traffic, checked every cycle by the model compare
    for (int i = 0; i < 3000; i++) begin
      logic [63:0] tgt;
      tgt = {$urandom, $urandom};
      if ($urandom_range(3) != 0) tgt[1:0] = 2'b00;
      drive($urandom_range(63) == 0, $urandom_range(3) == 0, $urandom_range(3) != 0,
            $urandom_range(5) == 0, tgt);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
